fp_mul_norm_round: RTL and testbench

FP_MUL_NORM_ROUND -- requirements
Module: fp_mul_norm_round

---
 rtl/fp_pkg.sv | 35 +++
 rtl/rne_rounder.sv | 26 ++
 rtl/fp_mul_norm_round.sv | 127 ++++++++++++
 tb/tb_fp_mul_norm_round.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants and the normalize-stage record for the
// multiplier back end (normalize, round, pack).
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int SIG_W    = 24;
    localparam int PROD_W   = 2 * SIG_W;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] ZERO    = 32'h0000_0000;

    // Normalized product plus the bits needed for rounding. The exponent
    // carries one extra bit so a normalization carry to 256 is not lost.
    typedef struct packed {
        logic              sign;
        logic [EXP_W:0]    exp;
        logic              ovf;
        logic              udf;
        logic              zero;
        logic [MANT_W-1:0] mant;
        logic              guard;
        logic              round;
        logic              sticky;
    } norm_t;

    // Signed infinity used for every overflowing result.
    function automatic logic [31:0] signed_inf(input logic sign);
        return sign ? NEG_INF : POS_INF;
    endfunction

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even on a 23-bit fraction given guard, round and sticky.
module rne_rounder
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              round,
    input  logic              sticky,
    output logic [MANT_W-1:0] rounded,
    output logic              carry,
    output logic              inexact
);

    logic          inc;
    logic [MANT_W:0] sum;

    // Round up above the halfway point, or exactly at it when the lsb is odd.
    always_comb begin
        inc     = guard & (round | sticky | mant[0]);
        sum     = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        rounded = sum[MANT_W-1:0];
        carry   = sum[MANT_W];
        inexact = guard | round | sticky;
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Two-stage back end of a single-precision multiplier: S1 normalizes the
// 48-bit significand product, S2 rounds to nearest-even and packs the
// IEEE-754 word with exception flags. The whole pipe stalls together.
module fp_mul_norm_round
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_ovf,
    input  logic              in_udf,
    input  logic              in_zero,
    input  logic [PROD_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_ovf,
    output logic              out_udf,
    output logic              out_inexact
);

    logic              advance;
    logic              s1_valid;
    norm_t             s1;
    norm_t             s1_next;
    logic [MANT_W-1:0] rnd_mant;
    logic              rnd_carry;
    logic              rnd_inexact;
    logic [EXP_W+1:0]  exp_final;
    logic [31:0]       pack_result;
    logic              pack_ovf;
    logic              pack_udf;
    logic              pack_inexact;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Pick the fraction window by the product's leading bit (1x or 2x range).
    always_comb begin
        s1_next      = '0;
        s1_next.sign = in_sign;
        s1_next.ovf  = in_ovf;
        s1_next.udf  = in_udf;
        s1_next.zero = in_zero;
        if (in_mant[47]) begin
            s1_next.mant   = in_mant[46:24];
            s1_next.guard  = in_mant[23];
            s1_next.round  = in_mant[22];
            s1_next.sticky = |in_mant[21:0];
            s1_next.exp    = {1'b0, in_exp} + 9'd1;
        end else begin
            s1_next.mant   = in_mant[45:23];
            s1_next.guard  = in_mant[22];
            s1_next.round  = in_mant[21];
            s1_next.sticky = |in_mant[20:0];
            s1_next.exp    = {1'b0, in_exp};
        end
    end

    // S1 register: loads a new beat (or a bubble) whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= s1_next;
            end
        end
    end

    rne_rounder u_rounder (
        .mant    (s1.mant),
        .guard   (s1.guard),
        .round   (s1.round),
        .sticky  (s1.sticky),
        .rounded (rnd_mant),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    // Pack the result; zero beats overflow, which beats underflow.
    always_comb begin
        exp_final    = {1'b0, s1.exp} + {{(EXP_W+1){1'b0}}, rnd_carry};
        pack_result  = {s1.sign, ZERO[30:0]};
        pack_ovf     = 1'b0;
        pack_udf     = 1'b0;
        pack_inexact = 1'b0;
        if (s1.zero) begin
            pack_result = {s1.sign, ZERO[30:0]};
        end else if (s1.ovf || exp_final >= 10'(EXP_MAX)) begin
            pack_result  = signed_inf(s1.sign);
            pack_ovf     = 1'b1;
            pack_inexact = 1'b1;
        end else if (s1.udf || exp_final == '0) begin
            pack_udf     = 1'b1;
            pack_inexact = 1'b1;
        end else begin
            pack_result  = {s1.sign, exp_final[EXP_W-1:0], rnd_mant};
            pack_inexact = rnd_inexact;
        end
    end

    // S2 / output register: holds the presented result while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_udf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= pack_result;
                out_ovf     <= pack_ovf;
                out_udf     <= pack_udf;
                out_inexact <= pack_inexact;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Randomized self-checking bench for fp_mul_norm_round with an arithmetic
// reference model, a result scoreboard and a few literal anchor cases.
module tb_fp_mul_norm_round;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        udf;
        logic        inexact;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic        in_ovf = 1'b0;
    logic        in_udf = 1'b0;
    logic        in_zero = 1'b0;
    logic [47:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_udf;
    logic        out_inexact;

    int   checks = 0;
    int   passes = 0;
    res_t exp_q[$];
    bit   held_valid = 1'b0;
    res_t held;
    bit   rand_ready_on = 1'b0;

    fp_mul_norm_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_ovf      (in_ovf),
        .in_udf      (in_udf),
        .in_zero     (in_zero),
        .in_mant     (in_mant),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_udf     (out_udf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: take the top 24 significant bits of the product, round the
    // discarded remainder to nearest-even by integer comparison with one half.
    function automatic res_t model(input logic sign, input logic [7:0] e,
                                   input logic ovf, input logic udf,
                                   input logic zero, input logic [47:0] m);
        longint unsigned mm, q, rem, half;
        int sh, ee;
        res_t r;
        mm   = {16'd0, m};
        sh   = m[47] ? 24 : 23;
        q    = mm >> sh;
        rem  = mm - (q << sh);
        half = 64'd1 << (sh - 1);
        ee   = int'(e) + (m[47] ? 1 : 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q >= (64'd1 << 24)) begin
            q  = q >> 1;
            ee = ee + 1;
        end
        r = '0;
        if (zero) begin
            r.result = {sign, 31'd0};
        end else if (ovf || ee >= 255) begin
            r.result = {sign, 8'hFF, 23'd0};
            r.ovf = 1'b1;
            r.inexact = 1'b1;
        end else if (udf || ee == 0) begin
            r.result = {sign, 31'd0};
            r.udf = 1'b1;
            r.inexact = 1'b1;
        end else begin
            r.result = {sign, 8'(ee), 23'(q)};
            r.inexact = (rem != 0);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        $display("[TB] FAIL %s: timed out waiting, expected event", name);
    endtask

    // Scoreboard: record accepted beats, check consumed results and stall hold.
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        if (rst_n) begin
            cur = {out_result, out_ovf, out_udf, out_inexact};
            if (out_valid) begin
                if (held_valid) checkOutput("hold_stable", 64'(cur), 64'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_result: got %h, expected no result", cur);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("result", 64'(cur), 64'(e));
                    end
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held = cur;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_sign, in_exp, in_ovf, in_udf, in_zero, in_mant));
        end
    end

    // Random downstream backpressure while enabled.
    always @(posedge clk) begin
        if (rand_ready_on) begin
            #1;
            if (rand_ready_on) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one beat starting at posedge+1 and hold it until accepted.
    task automatic applyStimulus(input logic sign, input logic [7:0] e, input logic ovf,
                                 input logic udf, input logic zero, input logic [47:0] m);
        bit ok = 1'b0;
        logic [47:0] junk;
        in_sign = sign; in_exp = e; in_ovf = ovf; in_udf = udf; in_zero = zero; in_mant = m;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) timeoutFail("accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        junk = {16'($urandom), 32'($urandom)};
        in_mant = junk;
        in_exp = 8'($urandom);
        in_zero = 1'($urandom);
    endtask

    task automatic randomBeat();
        logic [23:0] a, b;
        logic [7:0] e;
        int sel;
        a = 24'($urandom) | 24'h800000;
        b = 24'($urandom) | 24'h800000;
        sel = $urandom_range(0, 7);
        if (sel == 0) e = 8'($urandom_range(0, 2));
        else if (sel == 1) e = 8'($urandom_range(252, 255));
        else e = 8'($urandom_range(1, 254));
        applyStimulus(1'($urandom), e, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 15) == 0, 48'(a) * 48'(b));
    endtask

    // Single beat into an empty pipe: pin model and DUT to a literal, and latency.
    task automatic directedCase(input string name, input logic sign, input logic [7:0] e,
                                input logic ovf, input logic udf, input logic zero,
                                input logic [47:0] m, input res_t lit);
        int k;
        bit seen = 1'b0;
        checkOutput({name, "_model"}, 64'(model(sign, e, ovf, udf, zero, m)), 64'(lit));
        applyStimulus(sign, e, ovf, udf, zero, m);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        if (!seen) timeoutFail(name);
        else begin
            checkOutput(name, 64'({out_result, out_ovf, out_udf, out_inexact}), 64'(lit));
            checkOutput({name, "_latency"}, 64'(k), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_outputs", 64'({out_result, out_ovf, out_udf, out_inexact}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directedCase("one_x_one", 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 48'h4000_0000_0000, '{32'h3F80_0000, 1'b0, 1'b0, 1'b0});
        directedCase("1p5_sq", 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 48'h9000_0000_0000, '{32'h4010_0000, 1'b0, 1'b0, 1'b0});
        directedCase("round_carry", 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 48'h7FFF_FFC0_0000, '{32'h4000_0000, 1'b0, 1'b0, 1'b1});
        directedCase("ovf_pos", 1'b0, 8'd254, 1'b0, 1'b0, 1'b0, 48'h8000_0000_0000, '{32'h7F80_0000, 1'b1, 1'b0, 1'b1});
        directedCase("ovf_neg", 1'b1, 8'd254, 1'b0, 1'b0, 1'b0, 48'h8000_0000_0000, '{32'hFF80_0000, 1'b1, 1'b0, 1'b1});
        directedCase("zero_prio", 1'b1, 8'd127, 1'b1, 1'b1, 1'b1, 48'h8000_0000_0000, '{32'h8000_0000, 1'b0, 1'b0, 1'b0});
        directedCase("ovf_over_udf", 1'b0, 8'd100, 1'b1, 1'b1, 1'b0, 48'h4000_0000_0000, '{32'h7F80_0000, 1'b1, 1'b0, 1'b1});
        directedCase("exp_zero_flush", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 48'h4000_0000_0000, '{32'h8000_0000, 1'b0, 1'b1, 1'b1});
        directedCase("exp_zero_norm", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 48'h8000_0000_0000, '{32'h0080_0000, 1'b0, 1'b0, 1'b0});
        directedCase("udf_flag", 1'b0, 8'd127, 1'b0, 1'b1, 1'b0, 48'h4000_0000_0000, '{32'h0000_0000, 1'b0, 1'b1, 1'b1});
        directedCase("tie_even_down", 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 48'h4000_0040_0000, '{32'h3F80_0000, 1'b0, 1'b0, 1'b1});
        directedCase("sticky_up", 1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 48'h4000_0040_0001, '{32'h3F80_0001, 1'b0, 1'b0, 1'b1});

        // Backpressure: four back-to-back beats against a stalled sink
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) randomBeat();
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (out_valid) begin seen = 1'b1; break; end
                end
                if (!seen) timeoutFail("bp_first_result");
                checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
                repeat (2) @(negedge clk);
                checkOutput("bp_in_ready_still_low", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_all_delivered");

        // Reset with two beats in flight
        applyStimulus(1'b0, 8'd127, 1'b0, 1'b0, 1'b0, 48'h4000_0000_0000);
        applyStimulus(1'b1, 8'd130, 1'b0, 1'b0, 1'b0, 48'h9000_0000_0000);
        rst_n = 1'b0;
        exp_q.delete();
        held_valid = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midreset_outputs", 64'({out_result, out_ovf, out_udf, out_inexact}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and idle gaps
        rand_ready_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            randomBeat();
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready_on = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain("random_all_delivered");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
